// File: rtl/lap_stopwatch.sv
// Parametrised BCD stopwatch / count-down timer with lap freeze, feeding the
// seven-segment multiplexer. All state changes on the rising edge of clk.
module lap_stopwatch #(
    parameter int NUM_CLK_CYCLES = 10,
    parameter int NUM_DIGITS     = 4,
    parameter bit WRAP           = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_stop,
    input  logic                      clear,
    input  logic                      lap,
    input  logic                      mode,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      running,
    output logic                      lap_active,
    output logic                      done,
    output logic                      tick
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(NUM_CLK_CYCLES);
    localparam logic [PW-1:0] LAST      = PW'(NUM_CLK_CYCLES - 1);
    localparam logic [W-1:0]  ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

    state_t        state, state_n;
    logic [PW-1:0] count_reg, count_n;
    logic [W-1:0]  cnt, cnt_n, lap_reg, lap_n;
    logic          mode_reg, mode_n, lap_active_n, done_n;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    assign tick = (state == RUNNING) && (count_reg == LAST);

    always_comb begin
        state_n      = state;
        count_n      = count_reg;
        cnt_n        = cnt;
        lap_n        = lap_reg;
        mode_n       = mode_reg;
        lap_active_n = lap_active;
        done_n       = done;
        if (clear) begin
            cnt_n        = '0;
            count_n      = '0;
            done_n       = 1'b0;
            lap_active_n = 1'b0;
            if (state == EXPIRED) state_n = STOPPED;
        end else begin
            if (load && state != RUNNING) begin
                cnt_n   = bcd_sat(load_value);
                count_n = '0;
                done_n  = 1'b0;
                state_n = STOPPED;
            end else begin
                case (state)
                    STOPPED: begin
                        if (start_stop && !(mode && cnt == '0)) begin
                            state_n = RUNNING;
                            mode_n  = mode;
                        end
                    end
                    RUNNING: begin
                        count_n = tick ? '0 : count_reg + 1'b1;
                        if (tick) begin
                            if (mode_reg) begin
                                cnt_n = bcd_dec(cnt);
                                if (cnt_n == '0) begin
                                    done_n  = 1'b1;
                                    state_n = EXPIRED;
                                end
                            end else if (cnt == ALL_NINES && !WRAP) begin
                                state_n = STOPPED;
                            end else begin
                                cnt_n = bcd_inc(cnt);
                            end
                        end
                        // a coincident tick is applied first; stop only if it left us running
                        if (start_stop && state_n == RUNNING) state_n = STOPPED;
                    end
                    default: ;
                endcase
            end
            // lap sees the pre-update count so a coincident tick is not captured
            if (lap) begin
                if (lap_active) lap_active_n = 1'b0;
                else begin
                    lap_n        = cnt;
                    lap_active_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STOPPED;
            count_reg  <= '0;
            cnt        <= '0;
            lap_reg    <= '0;
            mode_reg   <= 1'b0;
            lap_active <= 1'b0;
            done       <= 1'b0;
            digits     <= '0;
            running    <= 1'b0;
        end else begin
            state      <= state_n;
            count_reg  <= count_n;
            cnt        <= cnt_n;
            lap_reg    <= lap_n;
            mode_reg   <= mode_n;
            lap_active <= lap_active_n;
            done       <= done_n;
            digits     <= lap_active_n ? lap_n : cnt_n;
            running    <= (state_n == RUNNING);
        end
    end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: expected display values are queued as
// stimulus is applied and compared one cycle after each tick.
module tb_lap_stopwatch;

    logic        clk = 1'b0;
    logic        rst, start_stop, clear, lap, mode, load;
    logic [15:0] load_value;
    logic [15:0] digits, digits_s;
    logic        running, lap_active, done, tick;
    logic        running_s, lap_active_s, done_s, tick_s;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic        sb_en = 1'b0;
    logic        sb_pending = 1'b0;
    int          n;

    always #5 clk = ~clk;

    lap_stopwatch #(.NUM_CLK_CYCLES(4), .NUM_DIGITS(4), .WRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .mode(mode), .load(load), .load_value(load_value), .digits(digits),
        .running(running), .lap_active(lap_active), .done(done), .tick(tick)
    );

    lap_stopwatch #(.NUM_CLK_CYCLES(4), .NUM_DIGITS(4), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .mode(mode), .load(load), .load_value(load_value), .digits(digits_s),
        .running(running_s), .lap_active(lap_active_s), .done(done_s), .tick(tick_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(); start_stop = 1'b1; cyc(); start_stop = 1'b0; endtask
    task automatic pulse_lap();   lap = 1'b1;        cyc(); lap = 1'b0;        endtask
    task automatic pulse_clear(); clear = 1'b1;      cyc(); clear = 1'b0;      endtask
    task automatic pulse_load(input logic [15:0] v);
        load_value = v; load = 1'b1; cyc(); load = 1'b0;
    endtask
    task automatic do_reset(); rst = 1'b1; cyc(); rst = 1'b0; endtask

    // Returns at the falling edge where tick is high; n = falling edges waited.
    task automatic wait_tick(output int cycles);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (tick) break;
        end
        if (k > 20) begin
            check("tick_timeout", 32'(tick), 32'd1);
            cycles = 0;
        end else begin
            cycles = k;
        end
    endtask

    always @(negedge clk) begin
        if (sb_pending) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("sb_digits", 32'(digits), 32'(exp_q.pop_front()));
        end
        sb_pending = sb_en && tick;
    end

    initial begin
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        mode = 1'b0; load = 1'b0; load_value = '0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_lap_active", 32'(lap_active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);

        // up count with carry
        for (int v = 1; v <= 44; v++) exp_q.push_back(to_bcd(v));
        sb_en = 1'b1;
        pulse_start();
        check("start_running", 32'(running), 32'd1);
        for (int i = 0; i < 44; i++) begin
            wait_tick(n);
            if (i < 3) check("tick_period", 32'(n), 32'd4);
        end
        cyc();
        sb_en = 1'b0;
        check("up_44", 32'(digits), 32'h0044);
        cyc();
        check("sb_drain_up", 32'(exp_q.size()), 32'd0);
        pulse_start();
        check("stop_running", 32'(running), 32'd0);
        pulse_load(16'h0099);
        check("load_99", 32'(digits), 32'h0099);
        exp_q.push_back(16'h0100);
        sb_en = 1'b1;
        pulse_start();
        wait_tick(n);
        check("first_tick_latency", 32'(n), 32'd4);
        cyc();
        sb_en = 1'b0;
        check("carry_99_100", 32'(digits), 32'h0100);
        cyc();
        check("sb_drain_carry", 32'(exp_q.size()), 32'd0);

        // wrap vs saturate
        do_reset();
        pulse_load(16'h9998);
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0000);
        sb_en = 1'b1;
        pulse_start();
        wait_tick(n);
        wait_tick(n);
        cyc();
        sb_en = 1'b0;
        check("wrap_digits", 32'(digits), 32'h0000);
        check("wrap_running", 32'(running), 32'd1);
        check("sat_digits", 32'(digits_s), 32'h9999);
        check("sat_running", 32'(running_s), 32'd0);
        cyc();
        check("sb_drain_wrap", 32'(exp_q.size()), 32'd0);

        // down timer
        do_reset();
        mode = 1'b1;
        pulse_load(16'h0102);
        for (int v = 101; v >= 0; v--) exp_q.push_back(to_bcd(v));
        sb_en = 1'b1;
        pulse_start();
        check("down_running", 32'(running), 32'd1);
        for (int i = 0; i < 102; i++) wait_tick(n);
        cyc();
        sb_en = 1'b0;
        check("down_zero", 32'(digits), 32'h0000);
        check("down_done", 32'(done), 32'd1);
        check("down_stopped", 32'(running), 32'd0);
        begin
            int t = 0;
            repeat (8) begin
                @(negedge clk);
                if (tick) t++;
            end
            check("expired_no_tick", 32'(t), 32'd0);
        end
        check("sb_drain_down", 32'(exp_q.size()), 32'd0);
        cyc();
        pulse_start();
        check("expired_ignores_start", 32'(running), 32'd0);
        check("expired_done_held", 32'(done), 32'd1);
        pulse_clear();
        check("clear_done", 32'(done), 32'd0);
        pulse_start();
        check("down_zero_start_ignored", 32'(running), 32'd0);
        pulse_load(16'h0003);
        pulse_start();
        check("stopped_after_clear", 32'(running), 32'd1);

        // pause and resume
        do_reset();
        mode = 1'b0;
        pulse_start();
        wait_tick(n);
        cyc();
        cyc();
        pulse_start();
        check("pause_running", 32'(running), 32'd0);
        begin
            int t = 0;
            repeat (10) begin
                cyc();
                if (tick) t++;
            end
            check("pause_no_tick", 32'(t), 32'd0);
        end
        check("pause_digits", 32'(digits), 32'h0001);
        pulse_start();
        wait_tick(n);
        check("resume_partial", 32'(n), 32'd2);
        cyc();
        check("resume_digits", 32'(digits), 32'h0002);

        // lap freeze
        do_reset();
        pulse_start();
        for (int i = 0; i < 17; i++) wait_tick(n);
        cyc();
        check("lap_pre", 32'(digits), 32'h0017);
        pulse_lap();
        check("lap_active_set", 32'(lap_active), 32'd1);
        for (int i = 0; i < 8; i++) begin
            wait_tick(n);
            if (i == 4) check("lap_frozen_mid", 32'(digits), 32'h0017);
        end
        cyc();
        check("lap_frozen_end", 32'(digits), 32'h0017);
        pulse_lap();
        check("lap_release", 32'(digits), 32'h0025);
        check("lap_active_clr", 32'(lap_active), 32'd0);
        wait_tick(n);
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        check("lap_on_tick", 32'(digits), 32'h0025);
        pulse_lap();
        check("lap_after_tick", 32'(digits), 32'h0026);

        // priority and reset
        wait_tick(n);
        cyc();
        pulse_load(16'h1234);
        check("load_while_running", 32'(digits), 32'h0027);
        check("load_keeps_running", 32'(running), 32'd1);
        pulse_lap();
        clear = 1'b1; load = 1'b1; lap = 1'b1; load_value = 16'h1234;
        cyc();
        clear = 1'b0; load = 1'b0; lap = 1'b0;
        check("clr_prio_digits", 32'(digits), 32'h0000);
        check("clr_prio_lap", 32'(lap_active), 32'd0);
        check("clr_prio_running", 32'(running), 32'd1);
        wait_tick(n);
        check("clr_prescaler", 32'(n), 32'd4);
        cyc();
        check("clr_count_on", 32'(digits), 32'h0001);
        pulse_lap();
        rst = 1'b1; start_stop = 1'b1; lap = 1'b1; clear = 1'b1;
        cyc();
        rst = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        check("midrst_digits", 32'(digits), 32'h0000);
        check("midrst_running", 32'(running), 32'd0);
        check("midrst_lap", 32'(lap_active), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_tick", 32'(tick), 32'd0);
        pulse_load(16'hAB3F);
        check("load_saturate", 32'(digits), 32'h9939);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
